// File: rtl/irom_loader_pkg.sv
// Shared definitions for the IROM boot loader: frame marker, FSM states, word sizing.
package irom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR_H = 4'd1,
    ST_ADDR_L = 4'd2,
    ST_CNT_H  = 4'd3,
    ST_CNT_L  = 4'd4,
    ST_DATA   = 4'd5,
    ST_CSUM   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

  // Bytes needed to carry one instruction word.
  function automatic int unsigned nb_of(input int unsigned data_w);
    return (data_w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler: byte i of a word lands in bits [8i+7:8i].
module loader_word_asm
  import irom_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        rx_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_ready
);

  localparam int unsigned NB    = nb_of(DATA_W);
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned BUF_W = NB * 8;

  logic [IDX_W-1:0] idx;
  logic [BUF_W-1:0] shreg;
  logic [BUF_W-1:0] merged;

  // Word as it looks with the incoming byte folded in; bits above DATA_W are dropped.
  always_comb begin
    merged     = shreg | (BUF_W'(rx_byte) << (8 * idx));
    word       = merged[DATA_W-1:0];
    word_ready = en && (idx == IDX_W'(NB - 1));
  end

  // Byte index and partial-word storage; cleared after each completed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      shreg <= '0;
    end else if (en) begin
      if (idx == IDX_W'(NB - 1)) begin
        idx   <= '0;
        shreg <= '0;
      end else begin
        idx   <= idx + IDX_W'(1);
        shreg <= merged;
      end
    end
  end

endmodule

// File: rtl/irom_loader.sv
// Byte-stream boot loader: parses framed program images into IROM writes and
// holds the CPU in reset until a frame with a good checksum has been loaded.
module irom_loader
  import irom_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_cpu_rstb,
  output logic              o_done,
  output logic              o_err
);

  state_t            state;
  logic [7:0]        addr_h;
  logic [7:0]        cnt_h;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       count;
  logic              we_q;
  logic              acc;
  logic              in_data;
  logic              word_ready;
  logic [DATA_W-1:0] word;
  logic              is_sync;

  // Handshake: ready everywhere but DONE, never while frozen or in reset.
  assign o_rx_ready = i_clk_en && !i_rst && (state != ST_DONE);
  assign acc        = o_rx_ready && i_rx_valid;
  assign in_data    = acc && (state == ST_DATA);
  assign is_sync    = (i_rx_data == SYNC_BYTE);
  // A strobe caught by a frozen cycle is presented on the next enabled cycle.
  assign o_we       = we_q && i_clk_en;

  loader_word_asm #(.DATA_W(DATA_W)) u_word_asm (
    .clk        (i_clk),
    .rst        (i_rst),
    .en         (in_data),
    .rx_byte    (i_rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Frame parser, address/count tracking, checksum and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      addr_h     <= '0;
      cnt_h      <= '0;
      csum       <= '0;
      addr       <= '0;
      count      <= '0;
      we_q       <= 1'b0;
      o_waddr    <= '0;
      o_wdata    <= '0;
      o_cpu_rstb <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else if (i_clk_en) begin
      we_q <= 1'b0;
      if (word_ready) begin
        we_q    <= 1'b1;
        o_waddr <= addr;
        o_wdata <= word;
        addr    <= addr + ADDR_W'(1);
      end
      if (acc) begin
        unique case (state)
          ST_IDLE: begin
            if (is_sync) begin
              csum  <= '0;
              state <= ST_ADDR_H;
            end
          end
          ST_ADDR_H: begin
            addr_h <= i_rx_data;
            state  <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            addr  <= ADDR_W'({addr_h, i_rx_data});
            state <= ST_CNT_H;
          end
          ST_CNT_H: begin
            cnt_h <= i_rx_data;
            state <= ST_CNT_L;
          end
          ST_CNT_L: begin
            count <= {cnt_h, i_rx_data};
            state <= ({cnt_h, i_rx_data} == 16'd0) ? ST_CSUM : ST_DATA;
          end
          ST_DATA: begin
            csum <= csum + i_rx_data;
            if (word_ready) begin
              count <= count - 16'd1;
              if (count == 16'd1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (i_rx_data == csum) begin
              o_done     <= 1'b1;
              o_cpu_rstb <= 1'b1;
              state      <= ST_DONE;
            end else begin
              o_err <= 1'b1;
              state <= ST_ERR;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          ST_ERR: begin
            if (is_sync) begin
              o_err <= 1'b0;
              csum  <= '0;
              state <= ST_ADDR_H;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irom_loader.sv
// Self-checking bench for irom_loader: directed frames plus randomized frames
// checked against a frame-parsing reference model.
module tb_irom_loader;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 10;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              cpu_rstb;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;
  bit gaps   = 1'b0;

  logic [ADDR_W-1:0] obs_addr[$];
  logic [DATA_W-1:0] obs_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  bit                exp_done;
  bit                exp_err;

  irom_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clk_en   (clk_en),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_we       (we),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .o_cpu_rstb (cpu_rstb),
    .o_done     (done),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen on the IROM port.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      obs_addr.push_back(waddr);
      obs_data.push_back(wdata);
    end
  end

  // Reference: scan the whole byte stream since reset and list the writes it implies.
  task automatic model(input bq_t s);
    int n, p, c, a, k;
    logic [7:0] sum;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = s.size();
    p = 0;
    while (p < n && !exp_done) begin
      if (s[p] != 8'hA5) begin
        p++;
        continue;
      end
      exp_err = 1'b0;
      p++;
      if (p + 4 > n) break;
      a = int'({s[p], s[p+1]}) % (1 << ADDR_W);
      c = int'({s[p+2], s[p+3]});
      p += 4;
      sum = 8'd0;
      for (k = 0; k < c && p + 3 <= n; k++) begin
        exp_addr.push_back(ADDR_W'(a));
        exp_data.push_back({s[p+2], s[p+1], s[p]});
        sum = sum + s[p] + s[p+1] + s[p+2];
        a = (a + 1) % (1 << ADDR_W);
        p += 3;
      end
      if (k < c || p >= n) break;
      if (s[p] == sum) exp_done = 1'b1;
      else             exp_err  = 1'b1;
      p++;
    end
  endtask

  function automatic bq_t make_frame(input logic [15:0] a, input int c, input bit bad);
    bq_t f;
    logic [7:0] s = 8'd0;
    logic [7:0] d;
    f.push_back(8'hA5);
    f.push_back(a[15:8]);
    f.push_back(a[7:0]);
    f.push_back(8'(c >> 8));
    f.push_back(8'(c));
    for (int i = 0; i < c * 3; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      f.push_back(d);
      s = s + d;
    end
    f.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit fired = 1'b0;
    int guard = 0;
    while (!fired) begin
      rx_data = b;
      if (gaps) begin
        clk_en   = ($urandom_range(0, 3) != 0);
        rx_valid = ($urandom_range(0, 3) != 0);
        if (!rx_valid) rx_data = 8'($urandom);
      end else begin
        clk_en   = 1'b1;
        rx_valid = 1'b1;
      end
      #1;
      if (!clk_en) begin
        checks++;
        if (rx_ready !== 1'b0) begin
          errors++;
          $display("FAIL rx_ready_frozen: got %b want 0", rx_ready);
        end
      end
      fired = clk_en && rx_valid && (rx_ready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
      if (!fired && guard > 200) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: byte %h not accepted in 200 cycles", b);
        fired = 1'b1;
      end
    end
    rx_valid = 1'b0;
    clk_en   = 1'b1;
  endtask

  task automatic send_stream(input bq_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    clk_en   = 1'b1;
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    clk_en   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic test_reset();
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
    checks++; if (waddr !== '0) begin errors++; $display("FAIL reset_waddr: got %h want 0", waddr); end
    checks++; if (wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    checks++; if (cpu_rstb !== 1'b0) begin errors++; $display("FAIL reset_cpu_rstb: got %b want 0", cpu_rstb); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    idle(1);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL idle_rx_ready: got %b want 1", rx_ready); end
  endtask

  task automatic test_basic_frame();
    bq_t f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
    do_reset();
    foreach (f[i]) begin
      send_byte(f[i]);
      if (i == 7) begin
        checks++;
        if (we !== 1'b1 || waddr !== 10'h010 || wdata !== 24'h332211) begin
          errors++;
          $display("FAIL basic_word0: got we=%b addr=%h data=%h want 1 010 332211", we, waddr, wdata);
        end
      end
      if (i == 10) begin
        checks++;
        if (we !== 1'b1 || waddr !== 10'h011 || wdata !== 24'h665544 || done !== 1'b0) begin
          errors++;
          $display("FAIL basic_word1: got we=%b addr=%h data=%h done=%b want 1 011 665544 0", we, waddr, wdata, done);
        end
      end
      if (i == 11) begin
        checks++;
        if (done !== 1'b1 || cpu_rstb !== 1'b1 || rx_ready !== 1'b0 || err !== 1'b0) begin
          errors++;
          $display("FAIL basic_done: got done=%b rstb=%b ready=%b err=%b want 1 1 0 0", done, cpu_rstb, rx_ready, err);
        end
      end
    end
    idle(3);
    checks++;
    if (obs_addr.size() != 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d want 2", obs_addr.size());
    end
  endtask

  task automatic test_bad_then_good();
    bq_t bad  = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h66};
    bq_t good = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    bq_t all;
    do_reset();
    send_stream(bad);
    idle(2);
    model(bad);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rstb !== 1'b0 || rx_ready !== 1'b1 || exp_err != 1'b1) begin
      errors++;
      $display("FAIL bad_csum_status: got err=%b done=%b rstb=%b ready=%b want 1 0 0 1", err, done, cpu_rstb, rx_ready);
    end
    send_byte(8'h5A);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_ignores_junk: got err=%b want 1", err); end
    send_byte(good[0]);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_sync: got err=%b want 0", err); end
    for (int i = 1; i < good.size(); i++) send_byte(good[i]);
    idle(3);
    all = bad;
    all.push_back(8'h5A);
    foreach (good[i]) all.push_back(good[i]);
    model(all);
    checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL recover_write_count: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL recover_write%0d: got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (done !== exp_done || err !== exp_err || cpu_rstb !== exp_done) begin
      errors++;
      $display("FAIL recover_status: got done=%b err=%b rstb=%b want %b %b %b", done, err, cpu_rstb, exp_done, exp_err, exp_done);
    end
  endtask

  task automatic test_junk_and_addr_wrap();
    bq_t s = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h06};
    do_reset();
    send_stream(s);
    idle(3);
    checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 10'h3FF || obs_data[0] !== 24'h030201) begin
      errors++;
      $display("FAIL junk_addr_mask: got n=%0d first=%h:%h want 1 3ff:030201", obs_addr.size(),
               (obs_addr.size() > 0) ? obs_addr[0] : 10'h0, (obs_data.size() > 0) ? obs_data[0] : 24'h0);
    end
    checks++;
    if (done !== 1'b1 || cpu_rstb !== 1'b1) begin
      errors++;
      $display("FAIL junk_done: got done=%b rstb=%b want 1 1", done, cpu_rstb);
    end
  endtask

  task automatic test_zero_count();
    bq_t s = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    send_stream(s);
    idle(3);
    checks++;
    if (obs_addr.size() != 0 || done !== 1'b1 || cpu_rstb !== 1'b1) begin
      errors++;
      $display("FAIL zero_count: got writes=%0d done=%b rstb=%b want 0 1 1", obs_addr.size(), done, cpu_rstb);
    end
  endtask

  task automatic test_mid_frame_reset();
    bq_t part = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    bq_t full = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    do_reset();
    send_stream(part);
    model(part);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (cpu_rstb !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got rstb=%b done=%b we=%b want 0 0 0", cpu_rstb, done, we);
    end
    idle(3);
    checks++;
    if (obs_addr.size() != exp_addr.size() || obs_addr.size() != 1 || obs_data[0] !== exp_data[0]) begin
      errors++;
      $display("FAIL midreset_partial: got writes=%0d want %0d", obs_addr.size(), exp_addr.size());
    end
    obs_addr.delete();
    obs_data.delete();
    send_stream(full);
    idle(3);
    model(full);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0] ||
        obs_addr[1] !== exp_addr[1] || obs_data[1] !== exp_data[1] || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reload: got writes=%0d done=%b want 2 1", obs_addr.size(), done);
    end
  endtask

  task automatic test_gaps();
    bq_t f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
    do_reset();
    gaps = 1'b1;
    send_stream(f);
    gaps = 1'b0;
    idle(3);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 10'h010 || obs_data[0] !== 24'h332211 ||
        obs_addr[1] !== 10'h011 || obs_data[1] !== 24'h665544) begin
      errors++;
      $display("FAIL gaps_writes: got n=%0d want 2 writes 010:332211 011:665544", obs_addr.size());
    end
    checks++;
    if (done !== 1'b1 || cpu_rstb !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done: got done=%b rstb=%b err=%b want 1 1 0", done, cpu_rstb, err);
    end
  endtask

  task automatic test_random();
    bq_t s, f;
    logic [15:0] a;
    logic [7:0] j;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      gaps = bit'($urandom_range(0, 1));
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        s.push_back(j);
      end
      if ($urandom_range(0, 2) == 0) begin
        a = 16'($urandom);
        f = make_frame(a, $urandom_range(0, 3), 1'b1);
        foreach (f[i]) s.push_back(f[i]);
      end
      a = 16'($urandom);
      if ($urandom_range(0, 2) == 0) a[9:0] = 10'h3FE;
      f = make_frame(a, $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
      foreach (f[i]) s.push_back(f[i]);
      send_stream(s);
      gaps = 1'b0;
      idle(3);
      model(s);
      checks++;
      if (obs_addr.size() != exp_addr.size()) begin
        errors++;
        $display("FAIL rand%0d_write_count: got %0d want %0d", it, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %h:%h want %h:%h", it, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if (done !== exp_done || err !== exp_err || cpu_rstb !== exp_done) begin
        errors++;
        $display("FAIL rand%0d_status: got done=%b err=%b rstb=%b want %b %b %b", it, done, err, cpu_rstb, exp_done, exp_err, exp_done);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    clk_en   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_frame();
    test_bad_then_good();
    test_junk_and_addr_wrap();
    test_zero_count();
    test_mid_frame_reset();
    test_gaps();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
